// File: rtl/mem_port_arbiter_if.sv
// Request, grant and shared-memory signals of the memory port arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
  logic        bootWrite;
  logic [31:0] bootAddress;
  logic [31:0] bootData;
  logic        bootDone;
  logic        fetchReq;
  logic [31:0] fetchAddress;
  logic        dataRead;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic [31:0] memDataOut;
  logic [31:0] memAddress;
  logic [31:0] memData;
  logic        memWE;
  logic        memOE;
  logic        memCS;
  logic        fetchGrant;
  logic        dataGrant;
  logic        fetchValid;
  logic        dataValid;
  logic [31:0] readData;
  logic        onBios;

  modport slave (
    input  bootWrite, bootAddress, bootData, bootDone,
    input  fetchReq, fetchAddress,
    input  dataRead, dataWrite, dataAddress, dataWriteData,
    input  memDataOut,
    output memAddress, memData, memWE, memOE, memCS,
    output fetchGrant, dataGrant, fetchValid, dataValid, readData, onBios
  );

  modport master (
    output bootWrite, bootAddress, bootData, bootDone,
    output fetchReq, fetchAddress,
    output dataRead, dataWrite, dataAddress, dataWriteData,
    output memDataOut,
    input  memAddress, memData, memWE, memOE, memCS,
    input  fetchGrant, dataGrant, fetchValid, dataValid, readData, onBios
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: BIOS loader in BOOT, then data-over-fetch priority in RUN.
// Define MEM_PORT_ARBITER_FAIRNESS_EN to add the fetch starvation breaker.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_bootWr, w_fetchGnt, w_dataGnt, w_dataReq, w_force;

  logic [31:0] r_memAddress_p1, r_memData_p1;
  logic        r_memWE_p1, r_memOE_p1, r_memCS_p1;
  logic        r_fetchRd_p1, r_dataRd_p1, r_dataWr_p1;
  logic [31:0] r_readData_p2;
  logic        r_fetchValid_p2, r_dataValid_p2;

  assign w_dataReq = bus.dataRead || bus.dataWrite;

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starveCnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_starveCnt <= '0;
    else if (r_state == RUN) begin
      if (w_fetchGnt)
        r_starveCnt <= '0;
      else if (bus.fetchReq)
        r_starveCnt <= sat_inc(r_starveCnt);
    end
  end

  assign w_force = (r_starveCnt >= LIMIT);
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bootWr    = 1'b0;
    w_fetchGnt  = 1'b0;
    w_dataGnt   = 1'b0;
    case (r_state)
      BOOT: begin
        w_bootWr = bus.bootWrite;
        if (bus.bootDone) w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.fetchReq && (w_force || !w_dataReq)) w_fetchGnt = 1'b1;
        else if (w_dataReq)                          w_dataGnt  = 1'b1;
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  // Stage p1: drive the memory bus for the access granted last cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_memAddress_p1 <= '0;
      r_memData_p1    <= '0;
      r_memWE_p1      <= 1'b0;
      r_memOE_p1      <= 1'b0;
      r_memCS_p1      <= 1'b1;
      r_fetchRd_p1    <= 1'b0;
      r_dataRd_p1     <= 1'b0;
      r_dataWr_p1     <= 1'b0;
    end else begin
      r_memWE_p1   <= w_bootWr || (w_dataGnt && bus.dataWrite);
      r_memOE_p1   <= w_fetchGnt || (w_dataGnt && !bus.dataWrite);
      r_memCS_p1   <= !(w_bootWr || w_fetchGnt || w_dataGnt);
      r_fetchRd_p1 <= w_fetchGnt;
      r_dataRd_p1  <= w_dataGnt && !bus.dataWrite;
      r_dataWr_p1  <= w_dataGnt && bus.dataWrite;
      if (w_bootWr) begin
        r_memAddress_p1 <= bus.bootAddress;
        r_memData_p1    <= bus.bootData;
      end else if (w_fetchGnt) begin
        r_memAddress_p1 <= bus.fetchAddress;
      end else if (w_dataGnt) begin
        r_memAddress_p1 <= bus.dataAddress;
        if (bus.dataWrite) r_memData_p1 <= bus.dataWriteData;
      end
    end
  end

  // Stage p2: capture read data at the end of the bus cycle and pulse valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_readData_p2   <= '0;
      r_fetchValid_p2 <= 1'b0;
      r_dataValid_p2  <= 1'b0;
    end else begin
      r_fetchValid_p2 <= r_fetchRd_p1;
      r_dataValid_p2  <= r_dataRd_p1 || r_dataWr_p1;
      if (r_fetchRd_p1 || r_dataRd_p1) r_readData_p2 <= bus.memDataOut;
    end
  end

  assign bus.memAddress = r_memAddress_p1;
  assign bus.memData    = r_memData_p1;
  assign bus.memWE      = r_memWE_p1;
  assign bus.memOE      = r_memOE_p1;
  assign bus.memCS      = r_memCS_p1;
  assign bus.fetchGrant = w_fetchGnt;
  assign bus.dataGrant  = w_dataGnt;
  assign bus.fetchValid = r_fetchValid_p2;
  assign bus.dataValid  = r_dataValid_p2;
  assign bus.readData   = r_readData_p2;
  assign bus.onBios     = (r_state == BOOT);

endmodule
